// File: rtl/dot_product_stream_if.sv
// Stream interface for dot_product_stream: beat input channel and result output channel.
// The slave modport is the engine's view, the master modport is the producer/consumer's view.
interface dot_product_stream_if #(
    parameter int LANES          = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int ACC_WIDTH      = 24,
    parameter int BEAT_CNT_WIDTH = 16
);
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES*DATA_WIDTH-1:0]   in_x;
    logic [LANES*DATA_WIDTH-1:0]   in_w;
    logic [LANES-1:0]              in_keep;
    logic                          in_last;
    logic                          out_valid;
    logic                          out_ready;
    logic [ACC_WIDTH-1:0]          out_dp;
    logic                          out_ovf;
    logic [BEAT_CNT_WIDTH-1:0]     out_beats;

    modport master (
        output in_valid, in_x, in_w, in_keep, in_last, out_ready,
        input  in_ready, out_valid, out_dp, out_ovf, out_beats
    );

    modport slave (
        input  in_valid, in_x, in_w, in_keep, in_last, out_ready,
        output in_ready, out_valid, out_dp, out_ovf, out_beats
    );
endinterface

// File: rtl/dot_product_stream.sv
// Streaming signed dot-product engine: lane products and tree sum in S1, cross-beat
// accumulation with saturate/wrap overflow handling in S2, one result per vector.
module dot_product_stream #(
    parameter int LANES          = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int ACC_WIDTH      = 24,
    parameter int SATURATE       = 1,
    parameter int BEAT_CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dot_product_stream_if.slave  bus
);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int P_W    = PROD_W + $clog2(LANES);
    localparam int SUM_W  = ((ACC_WIDTH > P_W) ? ACC_WIDTH : P_W) + 1;

    logic                              advance_s;
    logic                              xfer_s;
    logic signed [PROD_W-1:0]          lane_prod_s [LANES];
    logic signed [P_W-1:0]             p_sum_s;

    logic                              s1_valid_r;
    logic                              s1_last_r;
    logic signed [P_W-1:0]             s1_p_r;

    logic signed [SUM_W-1:0]           sum_s;
    logic                              ovf_s;
    logic signed [ACC_WIDTH-1:0]       acc_next_s;
    logic [BEAT_CNT_WIDTH-1:0]         beat_cnt_next_s;

    logic signed [ACC_WIDTH-1:0]       acc_r;
    logic                              ovf_acc_r;
    logic [BEAT_CNT_WIDTH-1:0]         beat_cnt_r;

    logic                              out_valid_r;
    logic signed [ACC_WIDTH-1:0]       out_dp_r;
    logic                              out_ovf_r;
    logic [BEAT_CNT_WIDTH-1:0]         out_beats_r;

    // A blocked output register freezes the whole pipeline, so readiness depends only on it.
    assign advance_s     = !out_valid_r || bus.out_ready;
    assign xfer_s        = bus.in_valid && advance_s;
    assign bus.in_ready  = advance_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_dp    = out_dp_r;
    assign bus.out_ovf   = out_ovf_r;
    assign bus.out_beats = out_beats_r;

    // Masked lane products and their full-precision sum.
    always_comb begin
        p_sum_s = {P_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (bus.in_keep[i]) begin
                lane_prod_s[i] = PROD_W'($signed(bus.in_x[i*DATA_WIDTH +: DATA_WIDTH]))
                               * PROD_W'($signed(bus.in_w[i*DATA_WIDTH +: DATA_WIDTH]));
            end else begin
                lane_prod_s[i] = {PROD_W{1'b0}};
            end
            p_sum_s = p_sum_s + P_W'(lane_prod_s[i]);
        end
    end

    // Accumulate with one guard bit; overflow is any sum whose upper bits are not a sign run.
    always_comb begin
        sum_s = SUM_W'(acc_r) + SUM_W'(s1_p_r);
        ovf_s = !((&sum_s[SUM_W-1:ACC_WIDTH-1]) || !(|sum_s[SUM_W-1:ACC_WIDTH-1]));
        if (ovf_s && (SATURATE != 32'sd0)) begin
            if (sum_s[SUM_W-1]) begin
                acc_next_s = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            end else begin
                acc_next_s = {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else begin
            acc_next_s = sum_s[ACC_WIDTH-1:0];
        end
        if (&beat_cnt_r) begin
            beat_cnt_next_s = beat_cnt_r;
        end else begin
            beat_cnt_next_s = beat_cnt_r + {{(BEAT_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // S1 register: captures the reduced beat, or a bubble when nothing transferred.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_p_r     <= {P_W{1'b0}};
        end else if (advance_s) begin
            s1_valid_r <= xfer_s;
            s1_last_r  <= bus.in_last;
            s1_p_r     <= p_sum_s;
        end
    end

    // S2 accumulator and output register; the last beat publishes and restarts the vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= {ACC_WIDTH{1'b0}};
            ovf_acc_r   <= 1'b0;
            beat_cnt_r  <= {BEAT_CNT_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_dp_r    <= {ACC_WIDTH{1'b0}};
            out_ovf_r   <= 1'b0;
            out_beats_r <= {BEAT_CNT_WIDTH{1'b0}};
        end else if (advance_s) begin
            if (s1_valid_r && s1_last_r) begin
                out_valid_r <= 1'b1;
                out_dp_r    <= acc_next_s;
                out_ovf_r   <= ovf_acc_r || ovf_s;
                out_beats_r <= beat_cnt_next_s;
                acc_r       <= {ACC_WIDTH{1'b0}};
                ovf_acc_r   <= 1'b0;
                beat_cnt_r  <= {BEAT_CNT_WIDTH{1'b0}};
            end else if (s1_valid_r) begin
                out_valid_r <= 1'b0;
                acc_r       <= acc_next_s;
                ovf_acc_r   <= ovf_acc_r || ovf_s;
                beat_cnt_r  <= beat_cnt_next_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dot_product_stream.sv
// Directed bench for dot_product_stream: one 24-bit saturating engine plus 16-bit
// saturating and wrapping engines fed by the same stream.
module tb_dot_product_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_x = 32'd0;
    logic [31:0] in_w = 32'd0;
    logic [3:0]  in_keep = 4'd0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    int checks = 0;
    int failures = 0;
    int exp_dp_q[$];
    int exp_beats_q[$];
    time t_first;
    time t_last;
    int total_beats;

    dot_product_stream_if #(.LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(24), .BEAT_CNT_WIDTH(16)) if_m ();
    dot_product_stream_if #(.LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(16), .BEAT_CNT_WIDTH(16)) if_s ();
    dot_product_stream_if #(.LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(16), .BEAT_CNT_WIDTH(16)) if_w ();

    assign if_m.in_valid = in_valid;  assign if_s.in_valid = in_valid;  assign if_w.in_valid = in_valid;
    assign if_m.in_x = in_x;          assign if_s.in_x = in_x;          assign if_w.in_x = in_x;
    assign if_m.in_w = in_w;          assign if_s.in_w = in_w;          assign if_w.in_w = in_w;
    assign if_m.in_keep = in_keep;    assign if_s.in_keep = in_keep;    assign if_w.in_keep = in_keep;
    assign if_m.in_last = in_last;    assign if_s.in_last = in_last;    assign if_w.in_last = in_last;
    assign if_m.out_ready = out_ready; assign if_s.out_ready = out_ready; assign if_w.out_ready = out_ready;

    dot_product_stream #(.LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(24), .SATURATE(1), .BEAT_CNT_WIDTH(16))
        dut_m (.clk(clk), .rst(rst), .bus(if_m));
    dot_product_stream #(.LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(16), .SATURATE(1), .BEAT_CNT_WIDTH(16))
        dut_s (.clk(clk), .rst(rst), .bus(if_s));
    dot_product_stream #(.LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(16), .SATURATE(0), .BEAT_CNT_WIDTH(16))
        dut_w (.clk(clk), .rst(rst), .bus(if_w));

    always #5 clk = ~clk;

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Drives one beat from a falling edge and returns just after the rising edge that takes it.
    task automatic send_beat(input logic [31:0] x, input logic [31:0] w, input logic [3:0] keep, input logic last);
        int n = 0;
        logic ok;
        @(negedge clk);
        in_valid = 1'b1; in_x = x; in_w = w; in_keep = keep; in_last = last;
        ok = if_m.in_ready;
        while (!ok && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            ok = if_m.in_ready;
            n++;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL send_timeout in_ready=%0b required=1", if_m.in_ready);
        end
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) begin
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic wait_out();
        int n = 0;
        while (if_m.out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL wait_out out_valid=%0b required=1", if_m.out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (if_m.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", if_m.out_valid); end
        checks++; if (if_m.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", if_m.in_ready); end
        checks++; if (if_m.out_dp !== 24'd0 || if_m.out_beats !== 16'd0 || if_m.out_ovf !== 1'b0) begin
            failures++; $display("FAIL reset_payload dp=%0d beats=%0d ovf=%0b exp=0/0/0", if_m.out_dp, if_m.out_beats, if_m.out_ovf);
        end
    endtask

    task automatic test_single_beat();
        out_ready = 1'b1;
        send_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'b1111, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (if_m.out_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%0b exp=0", if_m.out_valid); end
        @(negedge clk);
        checks++; if (if_m.out_valid !== 1'b1) begin failures++; $display("FAIL single_latency got=%0b exp=1", if_m.out_valid); end
        checks++; if ($signed(if_m.out_dp) !== 24'sd70) begin failures++; $display("FAIL single_dp got=%0d exp=70", $signed(if_m.out_dp)); end
        checks++; if (if_m.out_beats !== 16'd1 || if_m.out_ovf !== 1'b0) begin
            failures++; $display("FAIL single_meta beats=%0d ovf=%0b exp=1/0", if_m.out_beats, if_m.out_ovf);
        end
        checks++; if ($signed(if_w.out_dp) !== 16'sd70) begin failures++; $display("FAIL single_dp16 got=%0d exp=70", $signed(if_w.out_dp)); end
    endtask

    task automatic test_multi_beat();
        send_beat(pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), 4'b1111, 1'b0);
        send_beat(pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), 4'b1111, 1'b0);
        send_beat(pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), 4'b0011, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out();
        checks++; if (if_m.out_dp !== 24'd163840) begin failures++; $display("FAIL multi_dp got=%0d exp=163840", $signed(if_m.out_dp)); end
        checks++; if (if_m.out_beats !== 16'd3 || if_m.out_ovf !== 1'b0) begin
            failures++; $display("FAIL multi_meta beats=%0d ovf=%0b exp=3/0", if_m.out_beats, if_m.out_ovf);
        end
        checks++; if (if_s.out_dp !== 16'h7FFF || if_s.out_ovf !== 1'b1) begin
            failures++; $display("FAIL multi_sat16 dp=%0d ovf=%0b exp=32767/1", $signed(if_s.out_dp), if_s.out_ovf);
        end
        checks++; if (if_w.out_dp !== 16'h8000 || if_w.out_ovf !== 1'b1) begin
            failures++; $display("FAIL multi_wrap16 dp=%0d ovf=%0b exp=-32768/1", $signed(if_w.out_dp), if_w.out_ovf);
        end
        @(posedge clk);
    endtask

    task automatic test_overflow();
        send_beat(pack4(127, 127, 0, 0), pack4(127, 127, 0, 0), 4'b1111, 1'b0);
        send_beat(pack4(127, 127, 0, 0), pack4(127, 127, 0, 0), 4'b1111, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out();
        checks++; if (if_s.out_dp !== 16'sd32767 || if_s.out_ovf !== 1'b1) begin
            failures++; $display("FAIL ovf_sat dp=%0d ovf=%0b exp=32767/1", $signed(if_s.out_dp), if_s.out_ovf);
        end
        checks++; if ($signed(if_w.out_dp) !== -16'sd1020 || if_w.out_ovf !== 1'b1) begin
            failures++; $display("FAIL ovf_wrap dp=%0d ovf=%0b exp=-1020/1", $signed(if_w.out_dp), if_w.out_ovf);
        end
        checks++; if (if_m.out_dp !== 24'd64516 || if_m.out_ovf !== 1'b0 || if_m.out_beats !== 16'd2) begin
            failures++; $display("FAIL ovf_wide dp=%0d ovf=%0b beats=%0d exp=64516/0/2", $signed(if_m.out_dp), if_m.out_ovf, if_m.out_beats);
        end
        @(posedge clk);
    endtask

    task automatic test_stall();
        @(negedge clk);
        out_ready = 1'b0;
        send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 4'b1111, 1'b1);
        send_beat(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_x = pack4(2, 2, 2, 2); in_w = pack4(3, 3, 3, 3); in_keep = 4'b1111; in_last = 1'b1;
            checks++; if (if_m.in_ready !== 1'b0 || if_m.out_valid !== 1'b1 || if_m.out_dp !== 24'd4) begin
                failures++; $display("FAIL stall_hold cyc=%0d in_ready=%0b out_valid=%0b dp=%0d exp=0/1/4", i, if_m.in_ready, if_m.out_valid, $signed(if_m.out_dp));
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (if_m.out_valid !== 1'b1 || if_m.out_dp !== 24'd10 || if_m.out_beats !== 16'd1) begin
            failures++; $display("FAIL stall_next valid=%0b dp=%0d beats=%0d exp=1/10/1", if_m.out_valid, $signed(if_m.out_dp), if_m.out_beats);
        end
        @(negedge clk);
        checks++; if (if_m.out_valid !== 1'b1 || if_m.out_dp !== 24'd24 || if_m.out_beats !== 16'd1) begin
            failures++; $display("FAIL stall_third valid=%0b dp=%0d beats=%0d exp=1/24/1", if_m.out_valid, $signed(if_m.out_dp), if_m.out_beats);
        end
        @(posedge clk);
    endtask

    task automatic test_reset_midvector();
        out_ready = 1'b1;
        send_beat(pack4(5, 5, 5, 5), pack4(5, 5, 5, 5), 4'b1111, 1'b0);
        send_beat(pack4(5, 5, 5, 5), pack4(5, 5, 5, 5), 4'b1111, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (if_m.out_valid !== 1'b0 || if_m.in_ready !== 1'b1 || if_m.out_dp !== 24'd0) begin
            failures++; $display("FAIL midrst_state valid=%0b in_ready=%0b dp=%0d exp=0/1/0", if_m.out_valid, if_m.in_ready, $signed(if_m.out_dp));
        end
        send_beat(pack4(2, 2, 2, 2), pack4(3, 3, 3, 3), 4'b1111, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out();
        checks++; if (if_m.out_dp !== 24'd24 || if_m.out_beats !== 16'd1 || if_m.out_ovf !== 1'b0) begin
            failures++; $display("FAIL midrst_fresh dp=%0d beats=%0d ovf=%0b exp=24/1/0", $signed(if_m.out_dp), if_m.out_beats, if_m.out_ovf);
        end
        @(posedge clk);
    endtask

    // Random-length vectors against a reference sum; gaps=0 also checks zero-bubble throughput.
    task automatic test_stream(input int n_vec, input bit gaps);
        int got = 0;
        total_beats = 0;
        exp_dp_q.delete();
        exp_beats_q.delete();
        fork
            begin
                for (int v = 0; v < n_vec; v++) begin
                    int len = $urandom_range(1, 9);
                    int sum = 0;
                    for (int b = 0; b < len; b++) begin
                        logic [31:0] xv, wv;
                        logic [3:0] kv;
                        xv = $urandom; wv = $urandom; kv = 4'($urandom_range(0, 15));
                        for (int l = 0; l < 4; l++) begin
                            if (kv[l]) sum += int'($signed(xv[l*8 +: 8])) * int'($signed(wv[l*8 +: 8]));
                        end
                        if (b == len - 1) begin
                            exp_dp_q.push_back(sum);
                            exp_beats_q.push_back(len);
                        end
                        if (gaps) idle_cycles($urandom_range(0, 2));
                        send_beat(xv, wv, kv, (b == len - 1));
                        if (total_beats == 0) t_first = $time;
                        total_beats++;
                    end
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                int budget = 0;
                while (got < n_vec && budget < 3000) begin
                    @(negedge clk);
                    budget++;
                    if (if_m.out_valid === 1'b1 && out_ready === 1'b1) begin
                        int edp, ebt;
                        edp = (exp_dp_q.size() > 0) ? exp_dp_q.pop_front() : -1;
                        ebt = (exp_beats_q.size() > 0) ? exp_beats_q.pop_front() : -1;
                        checks++;
                        if ($signed(if_m.out_dp) !== 24'(edp) || int'(if_m.out_beats) != ebt || if_m.out_ovf !== 1'b0) begin
                            failures++;
                            $display("FAIL stream_vec%0d dp=%0d beats=%0d ovf=%0b exp=%0d/%0d/0", got, $signed(if_m.out_dp), if_m.out_beats, if_m.out_ovf, edp, ebt);
                        end
                        got++;
                        t_last = $time;
                    end
                    @(posedge clk);
                    #1;
                    out_ready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (got < n_vec) begin
                    checks++; failures++;
                    $display("FAIL stream_timeout got=%0d exp=%0d", got, n_vec);
                end
            end
        join
        out_ready = 1'b1;
        if (!gaps) begin
            checks++;
            if (t_last - t_first != time'(10 * total_beats + 5)) begin
                failures++;
                $display("FAIL stream_throughput elapsed=%0t exp=%0d", t_last - t_first, 10 * total_beats + 5);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_overflow();
        test_stall();
        test_reset_midvector();
        test_stream(12, 1'b0);
        test_stream(20, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dot_product_stream.md
# dot_product_stream

Streaming, pipelined signed dot-product engine, the sequential successor to the combinational dot-product unit. Vectors of arbitrary length arrive as a stream of `LANES`-wide beats under a valid/ready handshake, are multiplied lane-wise, reduced and accumulated across beats, and emitted as one `ACC_WIDTH` result per vector. Results can either saturate or wrap on overflow. The block feeds the NPU's activation and output stages and replaces the fixed-N combinational unit wherever vector length exceeds one beat.

## Interface
- `LANES`, 4: elements per beat (≥1).
- `DATA_WIDTH`, `` `DATA_WIDTH ``: signed element width of x and w.
- `ACC_WIDTH`, `` `ACC_WIDTH ``: signed result/accumulator width.
- `SATURATE`, 1: 1 = clamp on overflow; 0 = two's-complement wrap.
- `BEAT_CNT_WIDTH`, 16: width of the per-vector beat counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  beat present.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_x`  in  LANES*DATA_WIDTH  packed signed x; lane i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_w`  in  LANES*DATA_WIDTH  packed signed w, same packing.
- `in_keep`  in  LANES  per-lane enable; a lane with keep=0 contributes 0.
- `in_last`  in  1  final beat of the vector.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts the result.
- `out_dp`  out  ACC_WIDTH  signed dot product.
- `out_ovf`  out  1  overflow occurred at least once while accumulating this vector.
- `out_beats`  out  BEAT_CNT_WIDTH  number of beats in this vector.

## Operation
- Handshake: a beat transfers on `in_valid && in_ready`. A result transfers on `out_valid && out_ready`. Payload is held stable while `out_valid && !out_ready`.
- `advance = !out_valid || out_ready`. `in_ready = advance`. The whole pipeline stalls when `advance` = 0.
- Stage S1, registered on advance:
  - masked lane products, full precision 2*DATA_WIDTH.
  - adder-tree sum `p`, width P = 2*DATA_WIDTH + clog2(LANES).
  - `s1_valid` = transfer, `s1_last` = in_last.
  - S1 holds a bubble (`s1_valid` = 0) when no transfer occurs.
- Stage S2 (accumulate), on advance with `s1_valid`:
  - `sum = acc + p`, computed at width max(ACC_WIDTH, P) + 1, sign-extended.
  - Overflow means `sum` is outside the signed ACC_WIDTH range.
  - SATURATE=1: result is clamped to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
  - SATURATE=0: result is the low ACC_WIDTH bits.
  - Sticky `ovf_acc` is ORed with the overflow; `beat_cnt` increments and saturates at all-ones.
  - If `s1_last` = 0: `acc` takes the result.
  - If `s1_last` = 1: `out_dp`, `out_ovf` and `out_beats` load from the result, the sticky flag and count (including this beat). `out_valid` is set. `acc`, `ovf_acc` and `beat_cnt` clear to 0, so the next vector starts fresh.
- `out_valid` clears on output transfer unless a new result loads in the same cycle, in which case it stays 1 with the new payload.
- A one-beat vector (first beat is last) is legal. An all-keep=0 vector yields 0.
- Reset: `acc`, `ovf_acc`, `beat_cnt`, `s1_valid`, `out_valid`, `out_dp`, `out_ovf` and `out_beats` all become 0. `in_ready` = 1 in the first cycle after reset. Partial vectors in flight are discarded.

## Timing
- Latency: last beat accepted at edge E → S1 at E → output register at E+1. `out_valid` is high from the cycle after E+1.
- Throughput: one beat per cycle with no bubbles while `out_ready` is held 1. Back-to-back vectors need no gap.
- Stall: with `out_valid` = 1 and `out_ready` = 0, `in_ready` = 0. S1, S2 and the output register all hold.
- No combinational path from `in_valid` to `in_ready`. `out_ready` → `in_ready` is combinational.

## Test plan
- LANES=4, DATA_WIDTH=8, one beat x=[1,2,3,4], w=[5,6,7,8], last=1 → `out_dp`=70, `out_beats`=1, `out_ovf`=0, `out_valid` in the second cycle after acceptance.
- Three beats, all lanes x=-128, w=-128; beat 3 keep=4'b0011 → 16384×10 = 163840 (ACC_WIDTH=24), `out_beats`=3.
- ACC_WIDTH=16, two beats each x=[127,127,0,0], w=[127,127,0,0] → SATURATE=1: 32767, `out_ovf`=1. SATURATE=0: -1020, `out_ovf`=1.
- Hold `out_ready`=0 for 5 cycles with results pending → `in_ready`=0, `out_dp` stable, no beats lost. Then release: the next vector result follows correctly and `acc` starts from 0.
- Continuous random vectors of lengths 1–9 with random keep, random `in_valid`/`out_ready` gaps → results match a software model, in order.
- Assert `rst` midway through a 4-beat vector → next cycle `out_valid`=0 and `in_ready`=1. A following vector [2,2,2,2]·[3,3,3,3] → 24, with no contribution from the aborted vector.
